// File: rtl/exe_mul_sequencer.sv
// Iterative shift-and-add multiplier for the EXE stage (MUL/MLA).
// It stalls the front of the pipeline while iterating and presents the product for one DONE cycle.
module exe_mul_sequencer #(
  parameter int EARLY_TERM = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        accumulate,
  input  logic        S,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm,
  input  logic [31:0] Val_Rs,
  input  logic [3:0]  Dest_IN,
  input  logic [3:0]  SR_IN,
  input  logic        flush,
  output logic        freeze,
  output logic        busy,
  output logic        done,
  output logic [31:0] MUL_result,
  output logic [3:0]  Dest,
  output logic [3:0]  status,
  output logic        status_en
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  count_q, count_d;
  logic [3:0]  dest_cap_q, dest_cap_d;
  logic [1:0]  cv_cap_q, cv_cap_d;
  logic        s_cap_q, s_cap_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  dest_q, dest_d;
  logic [3:0]  status_q, status_d;
  logic [3:0]  final_status;
  logic        sr_nz_unused;

  // Only C and V are carried through; N and Z are regenerated from the product.
  assign sr_nz_unused = ^SR_IN[3:2];
  assign final_status = {acc_q[31], (acc_q == 32'd0), cv_cap_q};

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    count_d    = count_q;
    dest_cap_d = dest_cap_q;
    cv_cap_d   = cv_cap_q;
    s_cap_d    = s_cap_q;
    result_d   = result_q;
    dest_d     = dest_q;
    status_d   = status_q;
    freeze     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    status_en  = 1'b0;
    MUL_result = result_q;
    Dest       = dest_q;
    status     = status_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          mcand_d    = Val_Rm;
          mplier_d   = Val_Rs;
          acc_d      = accumulate ? Val_Rn : 32'd0;
          dest_cap_d = Dest_IN;
          cv_cap_d   = SR_IN[1:0];
          s_cap_d    = S;
          count_d    = 5'd0;
          freeze     = 1'b1;
          state_d    = ITER;
        end
      end
      ITER: begin
        busy   = 1'b1;
        freeze = !flush;
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + 5'd1;
          // Stop once no multiplier bits remain to be consumed.
          if ((count_q == 5'd31) || ((EARLY_TERM != 0) && (mplier_d == 32'd0))) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        state_d = IDLE;
        if (!flush) begin
          done       = 1'b1;
          status_en  = s_cap_q;
          MUL_result = acc_q;
          Dest       = dest_cap_q;
          status     = final_status;
          result_d   = acc_q;
          dest_d     = dest_cap_q;
          status_d   = final_status;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registers are already cleared during reset; only the start path is combinational.
    if (rst) begin
      freeze = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mcand_q    <= 32'd0;
      mplier_q   <= 32'd0;
      acc_q      <= 32'd0;
      count_q    <= 5'd0;
      dest_cap_q <= 4'd0;
      cv_cap_q   <= 2'd0;
      s_cap_q    <= 1'b0;
      result_q   <= 32'd0;
      dest_q     <= 4'd0;
      status_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      dest_cap_q <= dest_cap_d;
      cv_cap_q   <= cv_cap_d;
      s_cap_q    <= s_cap_d;
      result_q   <= result_d;
      dest_q     <= dest_d;
      status_q   <= status_d;
    end
  end

endmodule

// File: tb/tb_exe_mul_sequencer.sv
// Bench for exe_mul_sequencer: two instances (early termination on/off) share stimulus and are
// checked every cycle against a transaction-level model, plus directed literal expectations.
module tb_exe_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        accumulate = 1'b0;
  logic        S = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] Val_Rn = 32'd0;
  logic [31:0] Val_Rm = 32'd0;
  logic [31:0] Val_Rs = 32'd0;
  logic [3:0]  Dest_IN = 4'd0;
  logic [3:0]  SR_IN = 4'd0;

  logic [1:0]       freeze_o, busy_o, done_o, sen_o;
  logic [1:0][31:0] res_o;
  logic [1:0][3:0]  dest_o, st_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_mul_sequencer #(.EARLY_TERM(1)) dut_et (
    .clk(clk), .rst(rst), .start(start), .accumulate(accumulate), .S(S),
    .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .Val_Rs(Val_Rs), .Dest_IN(Dest_IN), .SR_IN(SR_IN),
    .flush(flush), .freeze(freeze_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .MUL_result(res_o[0]), .Dest(dest_o[0]), .status(st_o[0]), .status_en(sen_o[0])
  );

  exe_mul_sequencer #(.EARLY_TERM(0)) dut_full (
    .clk(clk), .rst(rst), .start(start), .accumulate(accumulate), .S(S),
    .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .Val_Rs(Val_Rs), .Dest_IN(Dest_IN), .SR_IN(SR_IN),
    .flush(flush), .freeze(freeze_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .MUL_result(res_o[1]), .Dest(dest_o[1]), .status(st_o[1]), .status_en(sen_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Iterations needed: bit length of the multiplier (at least one), or always 32.
  function automatic int iters(input logic [31:0] rs, input bit et);
    int n;
    n = 1;
    if (!et) return 32;
    for (int b = 0; b < 32; b++) begin
      if (rs[b]) n = b + 1;
    end
    return n;
  endfunction

  // ---------------- transaction-level reference model ----------------
  typedef enum int {P_IDLE, P_ITER, P_DONE} phase_t;
  phase_t      ph [2];
  int          left [2];
  logic [31:0] p_res [2], h_res [2];
  logic [3:0]  p_dest [2], h_dest [2], p_st [2], h_st [2];
  logic        p_s [2];
  logic        e_fr, e_busy, e_done, e_sen;
  logic [31:0] e_res;
  logic [3:0]  e_dest, e_st;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = P_IDLE; left[i] = 0;
      p_res[i] = 32'd0; h_res[i] = 32'd0;
      p_dest[i] = 4'd0; h_dest[i] = 4'd0; p_st[i] = 4'd0; h_st[i] = 4'd0;
      p_s[i] = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        e_fr = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_sen = 1'b0;
        e_res = h_res[i]; e_dest = h_dest[i]; e_st = h_st[i];
        if (rst) begin
          e_res = 32'd0; e_dest = 4'd0; e_st = 4'd0;
        end else begin
          case (ph[i])
            P_IDLE: e_fr = start & ~flush;
            P_ITER: begin e_fr = ~flush; e_busy = 1'b1; end
            default: begin
              e_busy = 1'b1;
              if (!flush) begin
                e_done = 1'b1; e_sen = p_s[i];
                e_res = p_res[i]; e_dest = p_dest[i]; e_st = p_st[i];
              end
            end
          endcase
        end
        chk($sformatf("freeze[%0d]", i), 32'(freeze_o[i]), 32'(e_fr));
        chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(e_busy));
        chk($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(e_done));
        chk($sformatf("status_en[%0d]", i), 32'(sen_o[i]), 32'(e_sen));
        chk($sformatf("MUL_result[%0d]", i), res_o[i], e_res);
        chk($sformatf("Dest[%0d]", i), 32'(dest_o[i]), 32'(e_dest));
        chk($sformatf("status[%0d]", i), 32'(st_o[i]), 32'(e_st));
      end
      if (rst) model_reset();

      @(posedge clk);
      if (rst) begin
        model_reset();
      end else begin
        for (int i = 0; i < 2; i++) begin
          case (ph[i])
            P_IDLE: begin
              if (start && !flush) begin
                ph[i]     = P_ITER;
                left[i]   = iters(Val_Rs, i == 0);
                p_res[i]  = Val_Rm * Val_Rs + (accumulate ? Val_Rn : 32'd0);
                p_dest[i] = Dest_IN;
                p_st[i]   = {p_res[i][31], (p_res[i] == 32'd0), SR_IN[1:0]};
                p_s[i]    = S;
              end
            end
            P_ITER: begin
              if (flush) begin
                ph[i] = P_IDLE;
              end else begin
                left[i]--;
                if (left[i] == 0) ph[i] = P_DONE;
              end
            end
            default: begin
              if (!flush) begin
                h_res[i] = p_res[i]; h_dest[i] = p_dest[i]; h_st[i] = p_st[i];
              end
              ph[i] = P_IDLE;
            end
          endcase
        end
      end
    end
  end

  // ---------------- directed operations with literal expectations ----------------
  task automatic run_op(input string tag, input logic [31:0] rn, input logic [31:0] rm,
                        input logic [31:0] rs, input logic a, input logic s,
                        input logic [3:0] sr, input logic [3:0] d,
                        input logic [31:0] x_res, input logic [3:0] x_st, input logic x_sen,
                        input int x_k0, input int x_k1);
    int  n, k0, k1;
    bit  seen0, seen1;
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b0; accumulate = a; S = s;
    Val_Rn = rn; Val_Rm = rm; Val_Rs = rs; SR_IN = sr; Dest_IN = d;
    @(posedge clk); #1;
    start = 1'b0; Val_Rn = $urandom; Val_Rm = $urandom; Val_Rs = $urandom;
    n = 1; k0 = -1; k1 = -1; seen0 = 1'b0; seen1 = 1'b0;
    while (!(seen0 && seen1) && n <= 40) begin
      @(negedge clk);
      if (done_o[0] && !seen0) begin
        seen0 = 1'b1; k0 = n - 1;
        chk({tag, " result"}, res_o[0], x_res);
        chk({tag, " status"}, 32'(st_o[0]), 32'(x_st));
        chk({tag, " status_en"}, 32'(sen_o[0]), 32'(x_sen));
        chk({tag, " dest"}, 32'(dest_o[0]), 32'(d));
      end
      if (done_o[1] && !seen1) begin
        seen1 = 1'b1; k1 = n - 1;
        chk({tag, " result full"}, res_o[1], x_res);
      end
      n++;
    end
    chk({tag, " iterations early"}, 32'(k0), 32'(x_k0));
    chk({tag, " iterations full"}, 32'(k1), 32'(x_k1));
    $display("op %s: rm=0x%08h rs=0x%08h result=0x%08h status=%04b iters=%0d/%0d",
             tag, rm, rs, res_o[0], st_o[0], k0, k1);
  endtask

  initial begin
    int ndone;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_op("mul7x6", 32'd0, 32'd7, 32'd6, 1'b0, 1'b1, 4'b0011, 4'd5,
           32'd42, 4'b0011, 1'b1, 3, 32);
    run_op("mla", 32'd100, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 4'b0000, 4'd9,
           32'h0000_0062, 4'b0000, 1'b0, 2, 32);

    // Flush on the fifth ITER cycle.
    @(posedge clk); #1;
    start = 1'b1; accumulate = 1'b0; S = 1'b1; Val_Rm = 32'd3; Val_Rs = 32'hF000_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush freeze", 32'(freeze_o[0]), 32'd0);
    chk("flush busy", 32'(busy_o[0]), 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush idle", 32'(busy_o[0]), 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o[0] || done_o[1]) ndone++;
    end
    chk("flush no done", 32'(ndone), 32'd0);
    chk("flush held result", res_o[0], 32'h0000_0062);
    chk("flush held result full", res_o[1], 32'h0000_0062);
    $display("op flush: result held 0x%08h", res_o[0]);

    run_op("zero", 32'd77, 32'd12345, 32'd0, 1'b0, 1'b1, 4'b0000, 4'd1,
           32'd0, 4'b0100, 1'b1, 1, 32);
    run_op("msb", 32'd0, 32'd3, 32'h8000_0000, 1'b0, 1'b1, 4'b0000, 4'hA,
           32'h8000_0000, 4'b1000, 1'b1, 32, 32);

    // Reset pulsed mid-ITER; start held high during reset must not raise freeze.
    @(posedge clk); #1;
    start = 1'b1; accumulate = 1'b1; Val_Rn = 32'd999; Val_Rm = 32'h1234_5678; Val_Rs = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; start = 1'b1;
    #2;
    chk("rst freeze", 32'(freeze_o[0]), 32'd0);
    chk("rst busy", 32'(busy_o[0]), 32'd0);
    chk("rst done", 32'(done_o[0]), 32'd0);
    chk("rst result", res_o[0], 32'd0);
    chk("rst dest", 32'(dest_o[0]), 32'd0);
    chk("rst status", 32'(st_o[0]), 32'd0);
    chk("rst status_en", 32'(sen_o[0]), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    $display("op reset: outputs cleared");
    run_op("after_rst", 32'd0, 32'd5, 32'd9, 1'b0, 1'b1, 4'b0010, 4'd3,
           32'd45, 4'b0010, 1'b1, 4, 32);

    // Randomized traffic, including start/flush collisions, checked by the model.
    repeat (1500) begin
      @(posedge clk); #1;
      start      = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 19) == 0);
      accumulate = 1'($urandom_range(0, 1));
      S          = 1'($urandom_range(0, 1));
      Val_Rn     = $urandom;
      Val_Rm     = $urandom;
      Val_Rs     = $urandom >> $urandom_range(0, 31);
      Dest_IN    = 4'($urandom);
      SR_IN      = 4'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
